// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM state type and helpers for the memory-access stage
package mem_pkg;
  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;
  localparam int TIMEOUT_DEFAULT = 255;
  typedef enum logic {IDLE, ACCESS} memState;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC} wbSel;
  function automatic wbSel pickWb(input logic pcToReg, input logic memToReg);
    return pcToReg ? WB_PC : memToReg ? WB_MEM : WB_ALU;
  endfunction
  // dsize 11 behaves as a word, so anything at or above DS_WORD needs offset 0
  function automatic logic isMisaligned(input logic [1:0] ds, input logic [1:0] off);
    return (ds == DS_HALF && off[0]) || (ds >= DS_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: big-endian store lane replication/byte enables and load lane extraction/extension
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  dsize,
  input  logic [1:0]  offset,
  input  logic        loadSign,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] loadData
);
  logic isByte, isHalf;
  logic [7:0] byteLane;
  logic [15:0] halfLane;
  // byte offset 0 is the most significant byte; be MSB enables offset 0
  always_comb begin
    isByte = dsize == DS_BYTE;
    isHalf = dsize == DS_HALF;
    byteLane = rdata[{~offset, 3'b000} +: 8];
    halfLane = offset[1] ? rdata[15:0] : rdata[31:16];
    wdata = isByte ? {4{storeData[7:0]}} : isHalf ? {2{storeData[15:0]}} : storeData;
    be = isByte ? 4'b1000 >> offset : isHalf ? (offset[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    loadData = isByte ? {{24{loadSign & byteLane[7]}}, byteLane}
             : isHalf ? {{16{loadSign & halfLane[15]}}, halfLane} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with req/ack data memory, stall generation and MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] next_pc,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] alu_result,
  input  logic        pc_to_reg,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        load_sign,
  input  logic [1:0]  dsize,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  memState state, stateNext;
  wbSel sel;
  logic [CW-1:0] cnt;
  logic [1:0] offset, lDsize, lOffset, alDsize, alOffset;
  logic inAcc, memOp, start, idleRetire, waiting, ackNow, timedOut, alSign;
  logic lSign, lMemToReg, lPcToReg, lRegWrite;
  logic [4:0] lDest;
  logic [31:0] lNextPc, alWdata, loadData, wbDataNext;
  logic [3:0] alBe;
  always_comb begin
    offset = alu_result[1:0];
    inAcc = state == ACCESS;
    memOp = in_valid & (mem_to_reg | mem_write);
    start = !inAcc & memOp & !isMisaligned(dsize, offset);
    idleRetire = !inAcc & in_valid & !start;
    waiting = inAcc & !dmem_ack & (cnt < TMAX);
    ackNow = inAcc & dmem_ack;
    timedOut = inAcc & !dmem_ack & (cnt == TMAX);
    stall = start | waiting;
    stateNext = start ? ACCESS : (ackNow | timedOut) ? IDLE : state;
    alDsize = inAcc ? lDsize : dsize;
    alOffset = inAcc ? lOffset : offset;
    alSign = inAcc ? lSign : load_sign;
  end
  mem_align u_align (
    .dsize(alDsize),
    .offset(alOffset),
    .loadSign(alSign),
    .storeData(op_b),
    .rdata(dmem_rdata),
    .wdata(alWdata),
    .be(alBe),
    .loadData(loadData)
  );
  // an outstanding op takes its writeback inputs from the copies latched at request time
  always_comb begin
    sel = inAcc ? pickWb(lPcToReg, lMemToReg) : pickWb(pc_to_reg, mem_to_reg);
    wbDataNext = sel == WB_PC ? (inAcc ? lNextPc : next_pc)
               : sel == WB_MEM ? loadData
               : inAcc ? {dmem_addr[31:2], lOffset} : alu_result;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= waiting ? cnt + 1'b1 : '0;
      dmem_req <= stateNext == ACCESS;
      if (start) begin
        dmem_we <= mem_write;
        dmem_addr <= {alu_result[31:2], 2'b00};
        dmem_wdata <= alWdata;
        dmem_be <= alBe;
      end
      wb_valid <= idleRetire | ackNow | timedOut;
      wb_reg_write <= idleRetire ? reg_write & !memOp : ackNow & lRegWrite & !dmem_we;
      wb_dest <= inAcc ? lDest : dest_reg;
      wb_data <= wbDataNext;
      misalign <= idleRetire & memOp;
      bus_err <= timedOut;
    end
  end
  always_ff @(posedge clk) begin
    if (start) begin
      lDsize <= dsize;
      lOffset <= offset;
      lSign <= load_sign;
      lMemToReg <= mem_to_reg;
      lPcToReg <= pc_to_reg;
      lRegWrite <= reg_write;
      lDest <= dest_reg;
      lNextPc <= next_pc;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic reset, in_valid, pc_to_reg, reg_write, mem_to_reg, mem_write, load_sign, dmem_ack;
  logic [31:0] next_pc, op_b, alu_result, dmem_rdata;
  logic [4:0] dest_reg;
  logic [1:0] dsize;
  logic stall, dmem_req, dmem_we, wb_valid, wb_reg_write, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0] dmem_be;
  logic [4:0] wb_dest;
  int errors = 0;
  int checks = 0;
  int lastStall;
  logic [31:0] lastWb, lastWd;
  logic [3:0] lastBe;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .next_pc(next_pc), .op_b(op_b),
    .dest_reg(dest_reg), .alu_result(alu_result), .pc_to_reg(pc_to_reg), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .load_sign(load_sign), .dsize(dsize),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One instruction through the stage; ackAt is the ACCESS-cycle index of the ack, > TO means never
  task automatic doOp(input logic isLd, input logic isSt, input logic [31:0] addr, input logic [31:0] opb,
                      input logic [31:0] npc, input logic [1:0] ds, input logic sgn, input logic rw,
                      input logic ptr, input logic [4:0] dst, input int ackAt, input logic [31:0] rd);
    int n, off;
    logic memop, mis, tmo, expW;
    logic [31:0] mask, wd, ld, exp;
    logic [3:0] be;
    n = ds == 2'd0 ? 1 : ds == 2'd1 ? 2 : 4;
    off = int'(addr[1:0]);
    memop = isLd | isSt;
    mis = memop && (off % n) != 0;
    mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    be = '0;
    wd = '0;
    ld = '0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) be |= 4'b1000 >> b;
    for (int c = 0; c < 4 / n; c++) wd |= (opb & mask) << (8 * n * c);
    if (!mis) begin
      for (int b = off; b < off + n; b++) ld = (ld << 8) | ((rd >> (24 - 8 * b)) & 32'hFF);
      if (sgn && n < 4 && ld[8 * n - 1]) ld |= ~mask;
    end
    tmo = memop && !mis && ackAt > TO;
    expW = rw && !isSt && !mis && !tmo;
    exp = ptr ? npc : isLd ? ld : addr;
    in_valid = 1'b1;
    alu_result = addr;
    op_b = opb;
    next_pc = npc;
    dsize = ds;
    load_sign = sgn;
    reg_write = rw;
    pc_to_reg = ptr;
    dest_reg = dst;
    mem_to_reg = isLd;
    mem_write = isSt;
    lastStall = 0;
    #1;
    chk("stall_present", stall, memop && !mis);
    if (stall) lastStall++;
    if (memop && !mis) begin
      for (int i = 0; i <= TO; i++) begin
        @(negedge clk);
        chk("req_high", dmem_req, 1'b1);
        chk("addr", dmem_addr, addr & ~32'd3);
        chk("we", dmem_we, isSt);
        chk("be", dmem_be, be);
        if (isSt) chk("wdata", dmem_wdata, wd);
        lastBe = dmem_be;
        lastWd = dmem_wdata;
        dmem_ack = i == ackAt;
        dmem_rdata = i == ackAt ? rd : $urandom;
        #1;
        chk("stall_access", stall, i != ackAt && i < TO);
        if (stall) lastStall++;
        if (i == ackAt || i == TO) break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    dmem_ack = 1'b0;
    mem_to_reg = 1'b0;
    mem_write = 1'b0;
    chk("wb_valid", wb_valid, 1'b1);
    chk("wb_reg_write", wb_reg_write, expW);
    chk("wb_dest", wb_dest, dst);
    chk("misalign", misalign, mis);
    chk("bus_err", bus_err, tmo);
    chk("req_low", dmem_req, 1'b0);
    if (expW) chk("wb_data", wb_data, exp);
    lastWb = wb_data;
    #1;
    chk("stall_after", stall, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    chk("idle_wb_valid", wb_valid, 1'b0);
    chk("idle_err", {misalign, bus_err}, 2'b00);
    chk("idle_req", dmem_req, 1'b0);
    chk("idle_stall", stall, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int k, ackAt;
    reset = 1'b0;
    {in_valid, pc_to_reg, reg_write, mem_to_reg, mem_write, load_sign, dmem_ack} = '0;
    {next_pc, op_b, alu_result, dmem_rdata} = '0;
    dest_reg = '0;
    dsize = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_wb", {wb_valid, wb_reg_write, misalign, bus_err}, 4'b0000);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_be", dmem_be, 4'h0);
    reset = 1'b1;
    doOp(0, 0, 32'h0000_1234, 32'h0, 32'h40, 2'd2, 0, 1, 0, 5'd5, 0, 32'h0);
    chk("tp_alu_data", lastWb, 32'h0000_1234);
    chk("tp_alu_nostall", lastStall, 0);
    doOp(1, 0, 32'h0000_0103, 32'h0, 32'h44, 2'd0, 1, 1, 0, 5'd7, 2, 32'h1122_3380);
    chk("tp_lb_stall3", lastStall, 3);
    chk("tp_lb_be", lastBe, 4'b0001);
    chk("tp_lb_data", lastWb, 32'hFFFF_FF80);
    doOp(1, 0, 32'h0000_0103, 32'h0, 32'h48, 2'd0, 0, 1, 0, 5'd7, 2, 32'h1122_3380);
    chk("tp_lbu_data", lastWb, 32'h0000_0080);
    doOp(0, 1, 32'h0000_0202, 32'h0000_BEEF, 32'h4C, 2'd1, 0, 1, 0, 5'd3, 1, 32'h0);
    chk("tp_sh_be", lastBe, 4'b0011);
    chk("tp_sh_wdata", lastWd, 32'hBEEF_BEEF);
    doOp(1, 0, 32'h0000_0205, 32'h0, 32'h50, 2'd2, 0, 1, 0, 5'd9, 0, 32'h0);
    doOp(1, 0, 32'h0000_0300, 32'h0, 32'h54, 2'd2, 0, 1, 0, 5'd10, TO + 1, 32'h0);
    chk("tp_timeout_stall", lastStall, 256);
    idle();
    doOp(1, 0, 32'h0000_0300, 32'h0, 32'h58, 2'd2, 0, 1, 0, 5'd11, TO, 32'hCAFE_F00D);
    chk("tp_ack_at_timeout", lastWb, 32'hCAFE_F00D);
    // reset in the second ACCESS cycle, then a stray ack
    in_valid = 1'b1;
    mem_to_reg = 1'b1;
    reg_write = 1'b1;
    pc_to_reg = 1'b0;
    dsize = 2'd2;
    alu_result = 32'h0000_0400;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc_req", dmem_req, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    mem_to_reg = 1'b0;
    #1;
    chk("rst_acc_req_low", dmem_req, 1'b0);
    chk("rst_acc_stall", stall, 1'b0);
    chk("rst_acc_wb", {wb_valid, wb_reg_write, misalign, bus_err}, 4'b0000);
    chk("rst_acc_addr", dmem_addr, 32'h0);
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_wb", wb_valid, 1'b0);
    chk("late_ack_req", dmem_req, 1'b0);
    for (int t = 0; t < 300; t++) begin
      k = int'($urandom_range(0, 3));
      if (k == 0) idle();
      ackAt = ($urandom % 60 == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
      doOp(k == 1, k == 2, $urandom & 32'h0000_0FFF, $urandom, $urandom, 2'($urandom), 1'($urandom),
           ($urandom % 8) != 0, ($urandom % 8) == 0, 5'($urandom), ackAt, $urandom);
    end
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage integer pipeline, between the EX/MEM pipeline register and the MEM/WB register. It performs loads and stores against a data memory with a req/ack handshake, and stalls the upstream pipeline while an access is outstanding. It aligns store data into byte lanes and sign- or zero-extends load data. It selects the writeback value and registers the result for MEM/WB.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of ACCESS cycles without ack before the access is abandoned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  EX/MEM holds a valid instruction
- next_pc  in  32  link value
- op_b  in  32  store data
- dest_reg  in  5  writeback register
- alu_result  in  32  effective address or ALU result
- pc_to_reg, reg_write, mem_to_reg, mem_write, load_sign  in  1 each  control from EX
- dsize  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- stall  out  1  hold EX/MEM and all earlier stages
- dmem_req, dmem_we  out  1  memory request and write enable
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables, be[0] = byte offset 0
- dmem_rdata  in  32
- dmem_ack  in  1  one-cycle completion pulse
- wb_valid, wb_reg_write  out  1
- wb_dest  out  5
- wb_data  out  32
- misalign, bus_err  out  1  one-cycle error pulses

## Operation
- Big-endian byte order. Bits are numbered [0:31], MSB first. Byte offset k occupies bits [8k:8k+7]. The offset is alu_result[30:31].
- mem_op = in_valid & (mem_to_reg | mem_write).
- Misalignment: a half access at an odd offset, or a word access at a nonzero offset. Such an op retires without a request, with wb_reg_write=0 and misalign=1.
- FSM states are IDLE and ACCESS.
  - IDLE → ACCESS on an aligned mem_op. Address, we, be, wdata and load controls are latched at this edge.
  - ACCESS → IDLE on dmem_ack, or when the wait counter reaches TIMEOUT.
- Store lanes:
  - byte: op_b[24:31] replicated ×4; be is one-hot at the offset.
  - half: op_b[16:31] replicated ×2; be = 1100 for offset 0, 0011 for offset 2.
  - word: be = 1111.
- Load: select the addressed lane from dmem_rdata, then sign-extend if load_sign=1, else zero-extend.
- Writeback value priority: pc_to_reg → next_pc; mem_to_reg → load data; otherwise alu_result.
- wb_reg_write = reg_write & no error.
- Stores never write a register.
- dmem_ack while in IDLE is ignored.

## Timing
- Reset values: state=IDLE, counter=0. All outputs are 0, including dmem_req, stall, wb_* and the error pulses.
- stall = (IDLE & aligned mem_op) | (ACCESS & !dmem_ack & counter<TIMEOUT). It is combinational.
- dmem_req is registered and is high for every ACCESS cycle. Address, data, be and we stay stable until ack or timeout.
- Non-memory op or misaligned op presented in cycle N: wb_valid=1 in cycle N+1.
- Memory op presented in cycle N: dmem_req is high from N+1. Ack in cycle M (M ≥ N+1) gives wb_valid in M+1.
- Counter increments each ACCESS cycle without ack. At TIMEOUT the FSM returns to IDLE, dmem_req drops the next cycle, and the op retires with bus_err=1 and wb_reg_write=0.
- wb_valid=0 in every cycle where nothing retires.
- Ack coincident with counter=TIMEOUT: the ack wins; no bus_err.
- Reset during ACCESS: next cycle is IDLE with req=0 and wb_valid=0. Any late ack is ignored.

## Structure
- Package mem_pkg holds:
  - the dsize encodings (DS_BYTE, DS_HALF, DS_WORD)
  - the FSM state enum
  - the TIMEOUT default
  - the writeback-select constants
- Sub-module mem_align is purely combinational and contains the store lane replication/be generation and the load lane extraction/extension.
- The FSM, counter and output register live in mem_stage.

## Test plan
- ALU op: alu_result=0x00001234, reg_write=1, dest_reg=5 → next cycle wb_valid=1, wb_data=0x00001234, wb_dest=5. No dmem_req and no stall.
- Signed byte load at 0x00000103. Memory returns 0x11223380 with ack 2 cycles after req rises. Expect stall high 3 cycles, dmem_addr=0x00000100, be=0001, wb_data=0xFFFFFF80. With load_sign=0, expect wb_data=0x00000080.
- Half store at 0x00000202 with op_b=0x0000BEEF → dmem_we=1, be=0011, wdata=0xBEEFBEEF; wb_reg_write=0.
- Word load at 0x00000205 → misalign pulse, no dmem_req, wb_valid=1 with wb_reg_write=0 in the next cycle.
- Load with ack withheld → bus_err after TIMEOUT ACCESS cycles, then dmem_req=0 and stall released. Repeat with ack on the TIMEOUT cycle → normal completion, no bus_err.
- reset low in the second ACCESS cycle → next cycle all outputs 0 and state IDLE. A following ack pulse produces no wb_valid.
